// File: rtl/instr_fetch_if.sv
// Fetch-stage bundle: ROM address/data, decode valid/ready, execute redirect.
// INSTR_FETCH_CNT_EN adds the o_fetch_cnt handshake counter.
interface instr_fetch_if #(
  parameter int unsigned ADDR_W = 14
);
  logic [ADDR_W-1:0] o_addr;
  logic [31:0]       i_rom_data;
  logic [31:0]       o_instr;
  logic [31:0]       o_pc;
  logic              o_valid;
  logic              i_ready;
  logic              i_redirect;
  logic [31:0]       i_redirect_pc;
  logic              o_misalign;
`ifdef INSTR_FETCH_CNT_EN
  logic [31:0]       o_fetch_cnt;
`endif

  modport master (
    output o_addr,
    input  i_rom_data,
    output o_instr,
    output o_pc,
    output o_valid,
    input  i_ready,
    input  i_redirect,
    input  i_redirect_pc,
    output o_misalign
`ifdef INSTR_FETCH_CNT_EN
    , output o_fetch_cnt
`endif
  );

  modport slave (
    input  o_addr,
    output i_rom_data,
    input  o_instr,
    input  o_pc,
    input  o_valid,
    output i_ready,
    output i_redirect,
    output i_redirect_pc,
    input  o_misalign
`ifdef INSTR_FETCH_CNT_EN
    , input o_fetch_cnt
`endif
  );
endinterface

// File: rtl/instr_fetch.sv
// Multicycle fetch stage: REQ -> CAP -> VALID per instruction, redirects from execute.
// Define INSTR_FETCH_CNT_EN to add the accepted-fetch counter o_fetch_cnt.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned ADDR_W   = 14
) (
  input logic           clk,
  input logic           rst,
  instr_fetch_if.master bus
);

  localparam logic [1:0] StReq   = 2'd0;
  localparam logic [1:0] StCap   = 2'd1;
  localparam logic [1:0] StValid = 2'd2;
  localparam logic [1:0] StErr   = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] opc_q, opc_d;
  logic        valid_q, valid_d;
  logic        misalign_q, misalign_d;
  logic        handshake;

  assign handshake = valid_q & bus.i_ready;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    opc_d      = opc_q;
    valid_d    = valid_q;
    misalign_d = misalign_q;

    if (bus.i_redirect) begin
      // Redirect wins in every state; any word in flight is simply never captured.
      pc_d    = bus.i_redirect_pc;
      valid_d = 1'b0;
      if (bus.i_redirect_pc[1:0] != 2'b00) begin
        state_d    = StErr;
        misalign_d = 1'b1;
      end else begin
        state_d    = StReq;
        misalign_d = 1'b0;
      end
    end else begin
      unique case (state_q)
        StReq: state_d = StCap;
        StCap: begin
          instr_d = bus.i_rom_data;
          opc_d   = pc_q;
          valid_d = 1'b1;
          state_d = StValid;
        end
        StValid: begin
          if (handshake) begin
            pc_d    = pc_q + 32'd4;
            valid_d = 1'b0;
            state_d = StReq;
          end
        end
        StErr: valid_d = 1'b0;
        default: state_d = StReq;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StReq;
      pc_q       <= RESET_PC;
      instr_q    <= 32'd0;
      opc_q      <= 32'd0;
      valid_q    <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      opc_q      <= opc_d;
      valid_q    <= valid_d;
      misalign_q <= misalign_d;
    end
  end

  assign bus.o_addr     = pc_q[ADDR_W-1:0];
  assign bus.o_instr    = instr_q;
  assign bus.o_pc       = opc_q;
  assign bus.o_valid    = valid_q;
  assign bus.o_misalign = misalign_q;

`ifdef INSTR_FETCH_CNT_EN
  logic [31:0] cnt_q;

  // A handshake coinciding with a redirect still counts: that instruction was accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 32'd0;
    end else if (handshake) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  assign bus.o_fetch_cnt = cnt_q;
`endif

endmodule
